// File: rtl/nib_sub_arbiter.sv
// Round-robin arbiter sharing one external 16-bit nibble-substitution unit
// between NUM_REQ requesters, with a single registered response slot.
module nib_sub_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [15:0]           sub_in,
    input  logic [15:0]           sub_out,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] start_idx;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] next_ptr;
    logic            grant_any;
    logic            can_accept;

    assign can_accept = !rsp_valid || rsp_ready;

    // Search from the highest offset down so the closest requester to rr_ptr wins last.
    always_comb begin
        start_idx = (int'(rr_ptr) < NUM_REQ) ? rr_ptr : '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (can_accept && !rst) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[(int'(start_idx) + k) % NUM_REQ]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'((int'(start_idx) + k) % NUM_REQ);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_any && (int'(grant_idx) == i);
        end
    end

    assign sub_in   = grant_any ? req_data[16*grant_idx +: 16] : 16'h0;
    assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : ID_W'(int'(grant_idx) + 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant_any) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sub_out;
            rsp_id    <= grant_idx;
            rr_ptr    <= next_ptr;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nib_sub_arbiter.sv
// Directed bench for nib_sub_arbiter with a reference S-AES nibble S-box on
// sub_in/sub_out and a response scoreboard queue.
module tb_nib_sub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic [15:0] sub_in;
    logic [15:0] sub_out;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;

    int tests = 0;
    int fails = 0;
    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        case (n)
            4'h0: sbox4 = 4'h9; 4'h1: sbox4 = 4'h4; 4'h2: sbox4 = 4'hA; 4'h3: sbox4 = 4'hB;
            4'h4: sbox4 = 4'hD; 4'h5: sbox4 = 4'h1; 4'h6: sbox4 = 4'h8; 4'h7: sbox4 = 4'h5;
            4'h8: sbox4 = 4'h6; 4'h9: sbox4 = 4'h2; 4'hA: sbox4 = 4'h0; 4'hB: sbox4 = 4'h3;
            4'hC: sbox4 = 4'hC; 4'hD: sbox4 = 4'hE; 4'hE: sbox4 = 4'hF; default: sbox4 = 4'h7;
        endcase
    endfunction

    function automatic logic [15:0] sbox16(input logic [15:0] s);
        sbox16 = {sbox4(s[15:12]), sbox4(s[11:8]), sbox4(s[7:4]), sbox4(s[3:0])};
    endfunction

    assign sub_out = sbox16(sub_in);

    nib_sub_arbiter #(.NUM_REQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .sub_in(sub_in), .sub_out(sub_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: check combinational grant and the response slot mid-cycle, then clock.
    task automatic tick(input logic [1:0] exp_rdy, input logic exp_vld, input string tag);
        logic [15:0] exp_sub;
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_vld));
        if (exp_vld) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            end else begin
                chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(sb_q[0][15:0]));
                chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(sb_q[0][16]));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
        exp_sub = exp_rdy[0] ? req_data[15:0] : (exp_rdy[1] ? req_data[31:16] : 16'h0);
        chk({tag, "_sub_in"}, 32'(sub_in), 32'(exp_sub));
        if (exp_rdy[0]) sb_q.push_back({1'b0, sbox16(req_data[15:0])});
        if (exp_rdy[1]) sb_q.push_back({1'b1, sbox16(req_data[31:16])});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_req_ready_in_rst"}, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rst_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rst_id"}, 32'(rsp_id), 32'd0);
        sb_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_data = 32'hFFFF_0000; rsp_ready = 1'b0;
        do_reset("init");

        // Single request
        req_valid = 2'b01; req_data = 32'h0000_1234; rsp_ready = 1'b1;
        tick(2'b01, 1'b0, "t1_grant");
        req_valid = 2'b00;
        tick(2'b00, 1'b1, "t1_rsp");
        chk("t1_sbox_const", 32'(rsp_data), 32'h4ABD);

        // Contention from a fresh pointer
        do_reset("t2");
        req_valid = 2'b11; req_data = 32'hFFFF_0000;
        tick(2'b01, 1'b0, "t2_g0");
        req_valid = 2'b10;
        tick(2'b10, 1'b1, "t2_g1");
        req_valid = 2'b00;
        tick(2'b00, 1'b1, "t2_r1");
        tick(2'b00, 1'b0, "t2_idle");

        // Back-to-back alternation, no bubbles
        req_valid = 2'b11; req_data = 32'h4567_0123;
        for (int k = 0; k < 6; k++) begin
            tick((k % 2 == 0) ? 2'b01 : 2'b10, k > 0, $sformatf("t3_c%0d", k));
        end
        req_valid = 2'b00;
        tick(2'b00, 1'b1, "t3_tail");

        // Backpressure holds the result and blocks grants
        req_valid = 2'b01; req_data = 32'h0000_A5A5;
        tick(2'b01, 1'b0, "t4_a");
        req_valid = 2'b10; req_data = 32'h3C3C_0000; rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(2'b00, 1'b1, $sformatf("t4_stall%0d", k));
            chk($sformatf("t4_hold%0d", k), 32'(rsp_data), 32'h0101);
        end
        rsp_ready = 1'b1;
        tick(2'b10, 1'b1, "t4_release");
        req_valid = 2'b00;
        tick(2'b00, 1'b1, "t4_tail");

        // Idle cycles keep the rotated priority
        req_valid = 2'b01; req_data = 32'h0000_5555;
        tick(2'b01, 1'b0, "t5_g0");
        req_valid = 2'b00;
        tick(2'b00, 1'b1, "t5_idle0");
        for (int k = 1; k < 5; k++) tick(2'b00, 1'b0, $sformatf("t5_idle%0d", k));
        req_valid = 2'b11; req_data = 32'h789A_FEDC;
        tick(2'b10, 1'b0, "t5_g1");
        req_valid = 2'b01;
        tick(2'b01, 1'b1, "t5_g0b");
        req_valid = 2'b00;
        tick(2'b00, 1'b1, "t5_tail");

        // Reset while a stalled response is pending
        req_valid = 2'b01; req_data = 32'h0000_1111;
        tick(2'b01, 1'b0, "t6_g0");
        req_valid = 2'b00; rsp_ready = 1'b0;
        tick(2'b00, 1'b1, "t6_stall");
        do_reset("t6");
        req_valid = 2'b11; req_data = 32'h2222_3333; rsp_ready = 1'b1;
        tick(2'b01, 1'b0, "t6_g0_after");
        req_valid = 2'b10;
        tick(2'b10, 1'b1, "t6_g1_after");
        req_valid = 2'b00;
        tick(2'b00, 1'b1, "t6_tail");
        tick(2'b00, 1'b0, "t6_idle");
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
